// File: rtl/risc_fsm_controller.sv
// Multi-cycle Moore control FSM for the Simple RISC Machine datapath, with stall cycles,
// an illegal-instruction trap and a saturating retired-instruction counter.
// Optional: define RISC_FSM_ERR_RECOVER_EN so the trap state falls back to WAIT (err stays sticky).
module risc_fsm_controller #(
    parameter int STALL_CYCLES = 0,
    parameter int COUNT_W      = 16,
    parameter int VSEL_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic [2:0]         opcode,
    input  logic [1:0]         op,
    output logic [2:0]         nsel,
    output logic [VSEL_W-1:0]  vsel,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic               loadc,
    output logic               loads,
    output logic               write,
    output logic               w,
    output logic               err,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        ST_WAIT      = 4'd0,
        ST_DECODE    = 4'd1,
        ST_GET_A     = 4'd2,
        ST_GET_B     = 4'd3,
        ST_EXEC      = 4'd4,
        ST_WRITE_REG = 4'd5,
        ST_WRITE_IMM = 4'd6,
        ST_DONE      = 4'd7,
        ST_STALL     = 4'd8,
        ST_ERR       = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_AND     = 3'd4,
        CLS_MVN     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_e;

    // The stall counter is loaded in DONE, so it starts one below the requested cycle count.
    localparam logic [3:0] STALL_LOAD = (STALL_CYCLES > 0) ? 4'(STALL_CYCLES - 1) : 4'd0;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    function automatic cls_e classify(input logic [2:0] opc, input logic [1:0] o);
        cls_e c;
        case ({opc, o})
            5'b110_10: c = CLS_MOV_IMM;
            5'b110_00: c = CLS_MOV_REG;
            5'b101_00: c = CLS_ADD;
            5'b101_01: c = CLS_CMP;
            5'b101_10: c = CLS_AND;
            5'b101_11: c = CLS_MVN;
            default:   c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic [3:0]         stall_q, stall_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic [2:0]         nsel_q, nsel_d;
    logic [VSEL_W-1:0]  vsel_q, vsel_d;
    logic               loada_q, loada_d;
    logic               loadb_q, loadb_d;
    logic               asel_q, asel_d;
    logic               bsel_q, bsel_d;
    logic               loadc_q, loadc_d;
    logic               loads_q, loads_d;
    logic               write_q, write_d;
    logic               w_q, w_d;

    // Next-state, instruction capture and stall/retire counter update.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        stall_d = stall_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    state_d = ST_DECODE;
                    cls_d   = classify(opcode, op);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (cls_q)
                    CLS_MOV_IMM:                  state_d = ST_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:         state_d = ST_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:    state_d = ST_GET_A;
                    default:                      state_d = ST_ERR;
                endcase
            end
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_EXEC;
            ST_EXEC: begin
                if (cls_q == CLS_CMP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_d = ST_DONE;
            ST_WRITE_IMM: state_d = ST_DONE;
            ST_DONE: begin
                if (STALL_CYCLES == 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_STALL;
                    stall_d = STALL_LOAD;
                end
            end
            ST_STALL: begin
                if (stall_q == 4'd0) begin
                    state_d = ST_WAIT;
                end else begin
                    stall_d = stall_q - 4'd1;
                end
            end
`ifdef RISC_FSM_ERR_RECOVER_EN
            ST_ERR:       state_d = ST_WAIT;
`else
            ST_ERR:       state_d = ST_ERR;
`endif
            default:      state_d = ST_WAIT;
        endcase

        if ((state_q == ST_DONE) && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end

        err_d = err_q | (state_d == ST_ERR);
    end

    // Output decode of the upcoming state so every strobe leaves a flop aligned with its state.
    always_comb begin
        nsel_d  = 3'b000;
        vsel_d  = '0;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        asel_d  = 1'b0;
        bsel_d  = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        write_d = 1'b0;
        w_d     = 1'b0;
        case (state_d)
            ST_WAIT: w_d = 1'b1;
            ST_GET_A: begin
                nsel_d  = 3'b001;
                loada_d = 1'b1;
            end
            ST_GET_B: begin
                nsel_d  = 3'b100;
                loadb_d = 1'b1;
            end
            ST_EXEC: begin
                asel_d = (cls_q == CLS_MOV_REG) || (cls_q == CLS_MVN);
                if (cls_q == CLS_CMP) begin
                    loads_d = 1'b1;
                end else begin
                    loadc_d = 1'b1;
                    loads_d = (cls_q != CLS_MOV_REG);
                end
            end
            ST_WRITE_REG: begin
                nsel_d    = 3'b010;
                vsel_d[0] = 1'b1;
                write_d   = 1'b1;
            end
            ST_WRITE_IMM: begin
                nsel_d    = 3'b001;
                vsel_d[2] = 1'b1;
                write_d   = 1'b1;
            end
            default: w_d = 1'b0;
        endcase
    end

    // State, counters and registered outputs; reset forces the idle WAIT picture immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            cls_q   <= CLS_MOV_IMM;
            stall_q <= 4'd0;
            count_q <= '0;
            err_q   <= 1'b0;
            nsel_q  <= 3'b000;
            vsel_q  <= '0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            write_q <= 1'b0;
            w_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            stall_q <= stall_d;
            count_q <= count_d;
            err_q   <= err_d;
            nsel_q  <= nsel_d;
            vsel_q  <= vsel_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            asel_q  <= asel_d;
            bsel_q  <= bsel_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            write_q <= write_d;
            w_q     <= w_d;
        end
    end

    assign nsel        = nsel_q;
    assign vsel        = vsel_q;
    assign loada       = loada_q;
    assign loadb       = loadb_q;
    assign asel        = asel_q;
    assign bsel        = bsel_q;
    assign loadc       = loadc_q;
    assign loads       = loads_q;
    assign write       = write_q;
    assign w           = w_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_risc_fsm_controller.sv
// Bench for risc_fsm_controller: three instances (default, STALL_CYCLES=3, COUNT_W=2) against a micro-op list model.
`timescale 1ns/1ps
module tb_risc_fsm_controller;

    // Output vector layout: {nsel[2:0], vsel[3:0], loada, loadb, asel, bsel, loadc, loads, write, w, err}
    localparam logic [15:0] B_NSEL_RN  = 16'h2000;
    localparam logic [15:0] B_NSEL_RD  = 16'h4000;
    localparam logic [15:0] B_NSEL_RM  = 16'h8000;
    localparam logic [15:0] B_VSEL_C   = 16'h0200;
    localparam logic [15:0] B_VSEL_IMM = 16'h0800;
    localparam logic [15:0] B_LOADA    = 16'h0100;
    localparam logic [15:0] B_LOADB    = 16'h0080;
    localparam logic [15:0] B_ASEL     = 16'h0040;
    localparam logic [15:0] B_LOADC    = 16'h0010;
    localparam logic [15:0] B_LOADS    = 16'h0008;
    localparam logic [15:0] B_WRITE    = 16'h0004;
    localparam logic [15:0] B_W        = 16'h0002;
    localparam logic [15:0] B_ERR      = 16'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [15:0] act_v [3];
    logic [15:0] cnt_v [3];
    logic [15:0] rec [40];
    int          n_checks = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SC = (g == 1) ? 3 : 0;
        localparam int CW = (g == 2) ? 2 : 16;
        logic [2:0]    nsel_l;
        logic [3:0]    vsel_l;
        logic          loada_l, loadb_l, asel_l, bsel_l, loadc_l, loads_l, write_l, w_l, err_l;
        logic [CW-1:0] cnt_l;
        risc_fsm_controller #(.STALL_CYCLES(SC), .COUNT_W(CW), .VSEL_W(4)) u_dut (
            .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
            .nsel(nsel_l), .vsel(vsel_l), .loada(loada_l), .loadb(loadb_l),
            .asel(asel_l), .bsel(bsel_l), .loadc(loadc_l), .loads(loads_l),
            .write(write_l), .w(w_l), .err(err_l), .instr_count(cnt_l)
        );
        assign act_v[g] = {nsel_l, vsel_l, loada_l, loadb_l, asel_l, bsel_l,
                           loadc_l, loads_l, write_l, w_l, err_l};
        assign cnt_v[g] = 16'(cnt_l);
    end

    // ---------------- model: each instruction is a list of micro-op cycles ----------------
    function automatic bit legal(input logic [4:0] ins);
        return (ins == 5'b11010) || (ins == 5'b11000) || (ins[4:2] == 3'b101);
    endfunction

    function automatic int body_len(input logic [4:0] ins);
        case (ins)
            5'b11010:                    return 3;
            5'b10100, 5'b10110:          return 6;
            5'b10101, 5'b11000, 5'b10111: return 5;
            default:                     return 1;
        endcase
    endfunction

    function automatic int stall_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 2) ? 3 : 65535;
    endfunction

    function automatic int total_len(input logic [4:0] ins, input int i);
        return legal(ins) ? body_len(ins) + stall_of(i) : 1;
    endfunction

    // Step 0 is decode and the last body step is the retire cycle; both, and all stall steps, are quiet.
    function automatic logic [15:0] step_vec(input logic [4:0] ins, input int k);
        logic [15:0] l [12];
        for (int j = 0; j < 12; j++) l[j] = 16'h0000;
        case (ins)
            5'b11010: l[1] = B_NSEL_RN | B_VSEL_IMM | B_WRITE;
            5'b10100, 5'b10110: begin
                l[1] = B_NSEL_RN | B_LOADA;
                l[2] = B_NSEL_RM | B_LOADB;
                l[3] = B_LOADC | B_LOADS;
                l[4] = B_NSEL_RD | B_VSEL_C | B_WRITE;
            end
            5'b10101: begin
                l[1] = B_NSEL_RN | B_LOADA;
                l[2] = B_NSEL_RM | B_LOADB;
                l[3] = B_LOADS;
            end
            5'b11000: begin
                l[1] = B_NSEL_RM | B_LOADB;
                l[2] = B_ASEL | B_LOADC;
                l[3] = B_NSEL_RD | B_VSEL_C | B_WRITE;
            end
            5'b10111: begin
                l[1] = B_NSEL_RM | B_LOADB;
                l[2] = B_ASEL | B_LOADC | B_LOADS;
                l[3] = B_NSEL_RD | B_VSEL_C | B_WRITE;
            end
            default: l[0] = 16'h0000;
        endcase
        return (k >= 0 && k < 12) ? l[k] : 16'h0000;
    endfunction

    bit         busy_m [3];
    bit         in_err_m [3];
    bit         err_m [3];
    logic [4:0] ins_m [3];
    int         pos_m [3];
    int         cnt_m [3];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                busy_m[i] <= 1'b0; in_err_m[i] <= 1'b0; err_m[i] <= 1'b0;
                ins_m[i] <= 5'b00000; pos_m[i] <= 0; cnt_m[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (in_err_m[i]) begin
`ifdef RISC_FSM_ERR_RECOVER_EN
                    in_err_m[i] <= 1'b0;
`else
                    in_err_m[i] <= 1'b1;
`endif
                end else if (busy_m[i]) begin
                    if (legal(ins_m[i]) && pos_m[i] == body_len(ins_m[i]) - 1 && cnt_m[i] < cnt_max(i))
                        cnt_m[i] <= cnt_m[i] + 1;
                    if (pos_m[i] + 1 >= total_len(ins_m[i], i)) begin
                        busy_m[i] <= 1'b0;
                        pos_m[i]  <= 0;
                        if (!legal(ins_m[i])) begin
                            in_err_m[i] <= 1'b1;
                            err_m[i]    <= 1'b1;
                        end
                    end else begin
                        pos_m[i] <= pos_m[i] + 1;
                    end
                end else if (s) begin
                    busy_m[i] <= 1'b1;
                    pos_m[i]  <= 0;
                    ins_m[i]  <= {opcode, op};
                end
            end
        end
    end

    logic [15:0] e_cmp;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                if (in_err_m[i])   e_cmp = B_ERR;
                else if (busy_m[i]) e_cmp = step_vec(ins_m[i], pos_m[i]) | (err_m[i] ? B_ERR : 16'h0000);
                else               e_cmp = B_W | (err_m[i] ? B_ERR : 16'h0000);
                n_checks++;
                if (act_v[i] !== e_cmp) begin
                    n_err++;
                    $display("FAIL cycle_outputs dut%0d t=%0t: got %04h expected %04h", i, $time, act_v[i], e_cmp);
                end
                n_checks++;
                if (cnt_v[i] !== 16'(cnt_m[i])) begin
                    n_err++;
                    $display("FAIL cycle_count dut%0d t=%0t: got %0d expected %0d", i, $time, cnt_v[i], cnt_m[i]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (act_v[0][1] && act_v[1][1] && act_v[2][1]) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nm, 32'(done), 32'd1);
    endtask

    task automatic run_instr(input logic [4:0] ins, output int lo0, output int lo1);
        bit done = 1'b0;
        @(negedge clk);
        {opcode, op} = ins;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        {opcode, op} = ~ins;
        lo0 = 0;
        lo1 = 0;
        for (int k = 0; k < 40; k++) begin
            rec[k] = act_v[0];
            if (act_v[0][1] && act_v[1][1] && act_v[2][1]) begin
                done = 1'b1;
                break;
            end
            if (!act_v[0][1]) lo0++;
            if (!act_v[1][1]) lo1++;
            @(negedge clk);
        end
        check("run_instr_timeout", 32'(done), 32'd1);
    endtask

    int lo0, lo1, lows_a, lows_b, bad;
    bit wrec [18];

    initial begin
        reset = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", act_v[0], 16'h0002);
        check("reset_count", cnt_v[0], 0);
        check("reset_outputs_stall", act_v[1], 16'h0002);
        reset = 1'b1;

        run_instr(5'b11010, lo0, lo1);
        check("movimm_wlow", lo0, 3);
        check("movimm_wlow_stall3", lo1, 6);
        check("movimm_write_cycle", rec[1], 16'h2804);
        check("movimm_count", cnt_v[0], 1);

        run_instr(5'b10100, lo0, lo1);
        check("add_wlow", lo0, 6);
        check("add_wlow_stall3", lo1, 9);
        check("add_get_a", rec[1], 16'h2100);
        check("add_get_b", rec[2], 16'h8080);
        check("add_exec", rec[3], 16'h0018);
        check("add_write", rec[4], 16'h4204);
        check("add_done", rec[5], 16'h0000);

        run_instr(5'b10101, lo0, lo1);
        check("cmp_wlow", lo0, 5);
        check("cmp_exec", rec[3], 16'h0008);
        check("cmp_no_write", rec[4], 16'h0000);

        run_instr(5'b10111, lo0, lo1);
        check("mvn_wlow", lo0, 5);
        check("mvn_get_b_first", rec[1], 16'h8080);
        check("mvn_exec", rec[2], 16'h0058);
        check("mvn_write", rec[3], 16'h4204);

        run_instr(5'b10110, lo0, lo1);
        check("and_wlow", lo0, 6);
        check("count_after_5", cnt_v[0], 5);
        check("count_saturated_w2", cnt_v[2], 3);

        // MOV reg with s held high on the STALL_CYCLES=3 instance
        @(negedge clk);
        {opcode, op} = 5'b11000;
        s = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            wrec[k] = act_v[1][1];
        end
        check("held_count_stall3", cnt_v[1], 7);
        s = 1'b0;
        lows_a = 0;
        lows_b = 0;
        for (int k = 0; k < 8; k++) begin
            if (!wrec[k]) lows_a++;
            if (!wrec[k + 9]) lows_b++;
        end
        check("held_first_wlow", lows_a, 8);
        check("held_one_idle", 32'(wrec[8]), 1);
        check("held_second_wlow", lows_b, 8);
        check("held_second_idle", 32'(wrec[17]), 1);
        wait_idle("held_drain_timeout");

        // asynchronous reset while ADD sits in GET_B
        @(negedge clk);
        {opcode, op} = 5'b10100;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_get_b", act_v[0], 16'h8080);
        #2 reset = 1'b0;
        #1;
        check("rst_async_outputs", act_v[0], 16'h0002);
        check("rst_async_count", cnt_v[0], 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_instr(5'b11010, lo0, lo1);
        check("post_rst_movimm_wlow", lo0, 3);
        check("post_rst_count", cnt_v[0], 1);

`ifdef RISC_FSM_ERR_RECOVER_EN
        @(negedge clk);
        {opcode, op} = 5'b11100;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        check("ill_decode", act_v[0], 16'h0000);
        @(negedge clk);
        check("ill_err_cycle", act_v[0], 16'h0001);
        @(negedge clk);
        check("ill_recovered_wait", act_v[0], 16'h0003);
        run_instr(5'b11010, lo0, lo1);
        check("ill_then_movimm_wlow", lo0, 3);
        check("ill_then_movimm_write", rec[1], 16'h2805);
        check("ill_then_count", cnt_v[0], 2);
`else
        @(negedge clk);
        {opcode, op} = 5'b11100;
        s = 1'b1;
        @(negedge clk);
        check("ill_decode", act_v[0], 16'h0000);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (act_v[0] !== 16'h0001) bad++;
        end
        check("ill_err_held_20", bad, 0);
        check("ill_count_unchanged", cnt_v[0], 1);
        s = 1'b0;
`endif

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_clears_err", act_v[0], 16'h0002);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
